// File: rtl/sort_eo_pkg.sv
// sort_eo_pkg: shared phase type and stage-number-to-phase mapping for the odd-even sorting network
package sort_eo_pkg;
   typedef enum logic {PH_ODD, PH_EVEN} phase_e;
   function automatic phase_e stage_phase(input int k);
      return (k % 2 == 1) ? PH_ODD : PH_EVEN;
   endfunction
endpackage

// File: rtl/sort_eo_stage.sv
// sort_eo_stage: one registered compare-exchange stage of the odd-even transposition network
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    load enable (pipeline advance); stage holds when low
//   in_valid/desc/data/idx  vector from the previous stage
//   out_valid/desc/data/idx registered vector after compare-exchange
module sort_eo_stage
   import sort_eo_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int NUM = 4,
   parameter phase_e PHASE = PH_ODD,
   localparam int IDXW = $clog2(NUM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic                   in_desc,
   input  logic [NUM*DWIDTH-1:0]  in_data,
   input  logic [NUM*IDXW-1:0]    in_idx,
   output logic                   out_valid,
   output logic                   out_desc,
   output logic [NUM*DWIDTH-1:0]  out_data,
   output logic [NUM*IDXW-1:0]    out_idx
);
   logic                  valid_q, valid_d, desc_q, desc_d;
   logic [NUM*DWIDTH-1:0] data_q, data_d, data_x;
   logic [NUM*IDXW-1:0]   idx_q, idx_d, idx_x;
   // Each lane knows its partner at elaboration time; a lane paired with itself passes through.
   for (genvar i = 0; i < NUM; i++) begin : g_lane
      localparam int P = (PHASE == PH_ODD) ? (i ^ 1) :
                         ((i == 0 || i == NUM - 1) ? i : ((i % 2 == 1) ? i + 1 : i - 1));
      localparam int L = (P < i) ? P : i;
      localparam int R = (P < i) ? i : P;
      logic [DWIDTH-1:0] kl, kr;
      logic              swap;
      assign kl   = in_data[L*DWIDTH +: DWIDTH];
      assign kr   = in_data[R*DWIDTH +: DWIDTH];
      // Strict compare: equal keys never swap, keeping the sort stable.
      assign swap = (L != R) && (in_desc ? (kl < kr) : (kl > kr));
      assign data_x[i*DWIDTH +: DWIDTH] = swap ? in_data[P*DWIDTH +: DWIDTH] : in_data[i*DWIDTH +: DWIDTH];
      assign idx_x[i*IDXW +: IDXW]      = swap ? in_idx[P*IDXW +: IDXW] : in_idx[i*IDXW +: IDXW];
   end
   always_comb begin
      valid_d = en ? in_valid : valid_q;
      desc_d  = en ? in_desc : desc_q;
      data_d  = en ? data_x : data_q;
      idx_d   = en ? idx_x : idx_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         desc_q  <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         valid_q <= valid_d;
         desc_q  <= desc_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
      end
   end
   assign out_valid = valid_q;
   assign out_desc  = desc_q;
   assign out_data  = data_q;
   assign out_idx   = idx_q;
endmodule

// File: rtl/sort_eo_pipe.sv
// sort_eo_pipe: pipelined stable odd-even transposition sorter, NUM lanes of unsigned keys per vector
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_desc selects descending order for this vector
//   in_data              lane i at [i*DWIDTH +: DWIDTH]
//   out_valid/out_ready  output handshake
//   out_data, out_idx    sorted keys (lane 0 first in sort order) and their original lane numbers
module sort_eo_pipe
   import sort_eo_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int NUM = 4,
   localparam int IDXW = $clog2(NUM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_desc,
   input  logic [NUM*DWIDTH-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM*DWIDTH-1:0]  out_data,
   output logic [NUM*IDXW-1:0]    out_idx
);
   logic                  advance;
   logic                  v0_q, v0_d, desc0_q, desc0_d;
   logic [NUM*DWIDTH-1:0] data0_q, data0_d;
   logic [NUM*IDXW-1:0]   idx0_q, idx0_d, idx_init;
   logic                  v_s    [NUM+1];
   logic                  dsc_s  [NUM+1];
   logic [NUM*DWIDTH-1:0] data_s [NUM+1];
   logic [NUM*IDXW-1:0]   idx_s  [NUM+1];
   // The whole pipeline moves in lockstep; any stall at the output freezes every stage.
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;
   always_comb begin
      idx_init = '0;
      for (int i = 0; i < NUM; i++) idx_init[i*IDXW +: IDXW] = IDXW'(i);
      v0_d    = advance ? (in_valid & in_ready) : v0_q;
      desc0_d = advance ? in_desc : desc0_q;
      data0_d = advance ? in_data : data0_q;
      idx0_d  = advance ? idx_init : idx0_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q    <= 1'b0;
         desc0_q <= 1'b0;
         data0_q <= '0;
         idx0_q  <= '0;
      end else begin
         v0_q    <= v0_d;
         desc0_q <= desc0_d;
         data0_q <= data0_d;
         idx0_q  <= idx0_d;
      end
   end
   assign v_s[0]    = v0_q;
   assign dsc_s[0]  = desc0_q;
   assign data_s[0] = data0_q;
   assign idx_s[0]  = idx0_q;
   for (genvar k = 1; k <= NUM; k++) begin : g_stage
      sort_eo_stage #(
         .DWIDTH (DWIDTH),
         .NUM    (NUM),
         .PHASE  (stage_phase(k))
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (advance),
         .in_valid  (v_s[k-1]),
         .in_desc   (dsc_s[k-1]),
         .in_data   (data_s[k-1]),
         .in_idx    (idx_s[k-1]),
         .out_valid (v_s[k]),
         .out_desc  (dsc_s[k]),
         .out_data  (data_s[k]),
         .out_idx   (idx_s[k])
      );
   end
   assign out_valid = v_s[NUM];
   assign out_data  = data_s[NUM];
   assign out_idx   = idx_s[NUM];
endmodule

// File: tb/tb_sort_eo_pipe.sv
// tb_sort_eo_pipe: self-checking bench for sort_eo_pipe with a selection-sort reference model
module tb_sort_eo_pipe;
   localparam int DWIDTH = 8;
   localparam int NUM = 4;
   localparam int IDXW = 2;
   localparam int NW = NUM * DWIDTH;
   localparam int NI = NUM * IDXW;
   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_desc = 1'b0;
   logic [NW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [NW-1:0] out_data;
   logic [NI-1:0] out_idx;
   int            total = 0;
   int            bad = 0;
   sort_eo_pipe #(.DWIDTH(DWIDTH), .NUM(NUM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_desc   (in_desc),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
   );
   always #5 clk = ~clk;
   // Reference: repeatedly pick the best unused key; strict compare keeps the lowest lane on ties.
   function automatic void ref_sort(input logic [NW-1:0] din, input logic desc,
                                    output logic [NW-1:0] dout, output logic [NI-1:0] iout);
      bit used [NUM];
      dout = '0;
      iout = '0;
      for (int j = 0; j < NUM; j++) used[j] = 1'b0;
      for (int p = 0; p < NUM; p++) begin
         int best;
         best = -1;
         for (int j = 0; j < NUM; j++) begin
            if (!used[j]) begin
               if (best < 0) best = j;
               else if (desc ? (din[j*DWIDTH +: DWIDTH] > din[best*DWIDTH +: DWIDTH])
                             : (din[j*DWIDTH +: DWIDTH] < din[best*DWIDTH +: DWIDTH])) best = j;
            end
         end
         used[best] = 1'b1;
         dout[p*DWIDTH +: DWIDTH] = din[best*DWIDTH +: DWIDTH];
         iout[p*IDXW +: IDXW] = IDXW'(best);
      end
   endfunction
   function automatic logic [DWIDTH-1:0] rkey();
      int sel;
      sel = $urandom_range(0, 3);
      return sel == 0 ? 8'h00 : sel == 1 ? 8'hFF : sel == 2 ? 8'($urandom_range(0, 3)) : 8'($urandom);
   endfunction
   function automatic logic [NW-1:0] rvec();
      logic [NW-1:0] v;
      for (int i = 0; i < NUM; i++) v[i*DWIDTH +: DWIDTH] = rkey();
      return v;
   endfunction
   // Pushes one vector into an empty pipeline and waits (bounded) for it to appear.
   task automatic send_and_wait(input logic [NW-1:0] din, input logic desc,
                                output logic [NW-1:0] od, output logic [NI-1:0] oi, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = din;
      in_desc = desc;
      out_ready = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      od = out_data;
      oi = out_idx;
   endtask
   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
      total++; if (out_idx !== '0) begin bad++; $display("FAIL reset_idx got=%h want=0", out_idx); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_directed;
      logic [NW-1:0] din [5];
      logic          dsc [5];
      logic [NW-1:0] ed  [5];
      logic [NI-1:0] ei  [5];
      logic [NW-1:0] od;
      logic [NI-1:0] oi;
      int            lat;
      din[0] = {8'd1, 8'd2, 8'd3, 8'd4};       dsc[0] = 1'b0;
      ed[0]  = {8'd4, 8'd3, 8'd2, 8'd1};       ei[0]  = {2'd0, 2'd1, 2'd2, 2'd3};
      din[1] = {8'd30, 8'd20, 8'd40, 8'd10};   dsc[1] = 1'b1;
      ed[1]  = {8'd10, 8'd20, 8'd30, 8'd40};   ei[1]  = {2'd0, 2'd2, 2'd3, 2'd1};
      din[2] = {8'd5, 8'd7, 8'd5, 8'd7};       dsc[2] = 1'b0;
      ed[2]  = {8'd7, 8'd7, 8'd5, 8'd5};       ei[2]  = {2'd2, 2'd0, 2'd3, 2'd1};
      din[3] = {8'h00, 8'hFF, 8'h00, 8'hFF};   dsc[3] = 1'b0;
      ed[3]  = {8'hFF, 8'hFF, 8'h00, 8'h00};   ei[3]  = {2'd2, 2'd0, 2'd3, 2'd1};
      din[4] = {8'h5A, 8'h5A, 8'h5A, 8'h5A};   dsc[4] = 1'b1;
      ed[4]  = {8'h5A, 8'h5A, 8'h5A, 8'h5A};   ei[4]  = {2'd3, 2'd2, 2'd1, 2'd0};
      for (int t = 0; t < 5; t++) begin
         send_and_wait(din[t], dsc[t], od, oi, lat);
         total++; if (lat !== NUM + 1) begin bad++; $display("FAIL directed%0d_latency got=%0d want=%0d", t, lat, NUM + 1); end
         total++; if (od !== ed[t]) begin bad++; $display("FAIL directed%0d_data got=%h want=%h", t, od, ed[t]); end
         total++; if (oi !== ei[t]) begin bad++; $display("FAIL directed%0d_idx got=%h want=%h", t, oi, ei[t]); end
      end
   endtask
   task automatic test_random;
      logic [NW-1:0] din, od, ed;
      logic [NI-1:0] oi, ei;
      logic          dsc;
      int            lat;
      for (int t = 0; t < 12; t++) begin
         din = rvec();
         dsc = 1'($urandom_range(0, 1));
         ref_sort(din, dsc, ed, ei);
         send_and_wait(din, dsc, od, oi, lat);
         total++; if (od !== ed || oi !== ei || lat !== NUM + 1)
            begin bad++; $display("FAIL random%0d got=%h/%h lat=%0d want=%h/%h lat=%0d", t, od, oi, lat, ed, ei, NUM + 1); end
      end
   endtask
   task automatic test_back_to_back;
      logic [NW-1:0] vec [8];
      logic [NW-1:0] qd [$];
      logic [NI-1:0] qi [$];
      logic [NW-1:0] pd, ed;
      logic [NI-1:0] pi, ei;
      logic          prev_stall = 1'b0;
      logic          stall;
      int            sent = 0, got = 0, c = 0;
      for (int i = 0; i < 8; i++) vec[i] = rvec();
      @(negedge clk);
      while (got < 8 && c < 60) begin
         stall = (c >= 7 && c <= 9);
         out_ready = !stall;
         in_valid = (sent < 8);
         in_data = (sent < 8) ? vec[sent] : '0;
         in_desc = sent[0];
         #1;
         total++; if (in_ready !== !stall) begin bad++; $display("FAIL stream_in_ready cycle=%0d got=%b want=%b", c, in_ready, !stall); end
         if (prev_stall) begin
            total++; if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi)
               begin bad++; $display("FAIL stream_hold cycle=%0d got=%b/%h/%h want=1/%h/%h", c, out_valid, out_data, out_idx, pd, pi); end
         end
         if (out_valid && out_ready) begin
            total++;
            if (qd.size() == 0) begin bad++; $display("FAIL stream_extra cycle=%0d got=%h want=none", c, out_data); end
            else begin
               ed = qd.pop_front();
               ei = qi.pop_front();
               if (out_data !== ed || out_idx !== ei)
                  begin bad++; $display("FAIL stream_vec%0d got=%h/%h want=%h/%h", got, out_data, out_idx, ed, ei); end
               got++;
            end
         end
         if (in_valid && in_ready) begin
            ref_sort(vec[sent], sent[0], ed, ei);
            qd.push_back(ed);
            qi.push_back(ei);
            sent++;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data;
         pi = out_idx;
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      total++; if (got !== 8) begin bad++; $display("FAIL stream_count got=%0d want=8", got); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b want=0", out_valid); end
   endtask
   task automatic test_reset_midflight;
      logic [NW-1:0] din, od, ed;
      logic [NI-1:0] oi, ei;
      logic          seen = 1'b0;
      int            lat, w = 0;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = rvec();
         in_desc = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      while (!out_valid && w < 10) begin
         @(posedge clk);
         @(negedge clk);
         w++;
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midflight_pre_valid got=%b want=1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midflight_async_valid got=%b want=0", out_valid); end
      total++; if (out_data !== '0 || out_idx !== '0) begin bad++; $display("FAIL midflight_async_data got=%h/%h want=0/0", out_data, out_idx); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midflight_in_ready got=%b want=1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midflight_stale got=%b want=0", seen); end
      din = rvec();
      ref_sort(din, 1'b0, ed, ei);
      send_and_wait(din, 1'b0, od, oi, lat);
      total++; if (lat !== NUM + 1) begin bad++; $display("FAIL midflight_latency got=%0d want=%0d", lat, NUM + 1); end
      total++; if (od !== ed || oi !== ei) begin bad++; $display("FAIL midflight_vec got=%h/%h want=%h/%h", od, oi, ed, ei); end
   endtask
   initial begin
      test_reset;
      test_directed;
      test_random;
      test_back_to_back;
      test_reset_midflight;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
